// File: rtl/mem_access_ctrl.sv
// EX/MEM consumer: runs one data-memory access per instruction,
// stalls the pipeline while outstanding, returns load data to MEM/WB.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT     = 15,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_halt,
  input  logic [15:0] ex_addr,
  input  logic [15:0] ex_wdata,
  input  logic        flush,
  output logic        dmem_en,
  output logic        dmem_wr,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_done,
  input  logic        dmem_stall,
  output logic        mem_stall,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        align_err,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t     state, state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       flushed;
  logic       req;
  logic       misaligned;

  assign req = ex_valid
             & (ex_mem_read | ex_mem_write)
             & ~ex_halt;
  assign misaligned = ALIGN_CHECK && ex_addr[0];
  assign cnt_inc = cnt + 8'd1;
  assign busy = (state != IDLE);

  always_comb begin
    state_nx  = state;
    mem_stall = 1'b0;
    dmem_en   = 1'b0;
    align_err = 1'b0;
    rd_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && misaligned) begin
          align_err = 1'b1;
        end else if (req && !flush) begin
          mem_stall = 1'b1;
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        mem_stall = 1'b1;
        if (!dmem_stall) begin
          dmem_en  = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (dmem_done || cnt_inc == TO)
          state_nx = DONE;
      end
      DONE: begin
        rd_valid = ~dmem_wr & ~flushed & ~flush;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // req is combinational, so keep the IDLE outputs quiet in reset
    if (!rst) begin
      mem_stall = 1'b0;
      align_err = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      flushed     <= 1'b0;
      dmem_wr     <= 1'b0;
      dmem_addr   <= 16'h0000;
      dmem_wdata  <= 16'h0000;
      rd_data     <= 16'h0000;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (state_nx == ISSUE) begin
            dmem_addr  <= ex_addr;
            dmem_wdata <= ex_wdata;
            dmem_wr    <= ex_mem_write;
            flushed    <= flush;
          end
        end
        ISSUE: begin
          if (flush)   flushed <= 1'b1;
          if (dmem_en) cnt     <= 8'd0;
        end
        WAIT: begin
          if (flush) flushed <= 1'b1;
          if (dmem_done) begin
            if (!dmem_wr) rd_data <= dmem_rdata;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TO) begin
              timeout_err <= 1'b1;
              rd_data     <= 16'h0000;
            end
          end
        end
        DONE: begin
          if (flush) flushed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
